// File: rtl/hd63701_exec_gen.sv
// HD63701-style micro-op execution datapath: register file, NZVC flags, X, PC and a req/ack memory cycle.
// Optional bus timeout enabled by defining HD63701_EXEC_GEN_TIMEOUT_EN.
module hd63701_exec_gen #(
    parameter int DW       = 8,
    parameter int AW       = 16,
    parameter int NREG     = 4,
    parameter int RESET_PC = 0,
    parameter int WAIT_MAX = 15,
    localparam int RI      = $clog2(NREG)
) (
    input  logic          CLK,
    input  logic          RST_N,
    // Handshake: a micro-op transfers on a rising edge where uop_valid & uop_ready are both 1;
    // the sender holds all uop_* fields stable until then, uop_ready never depends on uop_valid.
    input  logic          uop_valid,
    output logic          uop_ready,
    input  logic [3:0]    uop_op,
    input  logic [RI-1:0] uop_rd,
    input  logic [RI-1:0] uop_rs,
    input  logic [DW-1:0] uop_imm,
    input  logic [3:0]    uop_cond,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic [AW-1:0] pc,
    output logic [3:0]    flags,
    output logic [AW-1:0] xreg,
    output logic          err,
    input  logic [RI-1:0] dbg_sel,
    output logic [DW-1:0] dbg_data,
    output logic          dbg_state
);
    typedef enum logic {S_IDLE = 1'b0, S_MEM = 1'b1} state_t;

    localparam logic [3:0] OP_LDI = 4'h1, OP_MOV = 4'h2, OP_ADD = 4'h3, OP_ADC = 4'h4;
    localparam logic [3:0] OP_SUB = 4'h5, OP_AND = 4'h6, OP_OR  = 4'h7, OP_XOR = 4'h8;
    localparam logic [3:0] OP_LD  = 4'h9, OP_ST  = 4'hA, OP_LDX = 4'hB, OP_BRA = 4'hC;
    localparam logic [3:0] OP_INX = 4'hD, OP_TST = 4'hE;

    state_t        state_q, state_d;
    logic [DW-1:0] regs_q [NREG];
    logic [AW-1:0] x_q, x_d, pc_q, pc_d, addr_q, addr_d;
    logic [3:0]    flags_q, flags_d;
    logic          we_q, we_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [RI-1:0] rd_q, rd_d;
    logic          reg_we;
    logic [RI-1:0] reg_wa;
    logic [DW-1:0] reg_wd;
    logic [DW-1:0] op_a, op_b;
    logic [DW:0]   add_sum, sub_dif;
    logic          carry_in, cond_sel, taken, accept, expired;

    function automatic logic [3:0] nz_flags(input logic [DW-1:0] r, input logic c);
        return {r[DW-1], (r == '0), 1'b0, c};
    endfunction

    assign accept   = (state_q == S_IDLE) && uop_valid;
    assign op_a     = regs_q[uop_rd];
    assign op_b     = regs_q[uop_rs];
    assign carry_in = (uop_op == OP_ADC) && flags_q[0];
    assign add_sum  = {1'b0, op_a} + {1'b0, op_b} + {{DW{1'b0}}, carry_in};
    assign sub_dif  = {1'b0, op_a} - {1'b0, op_b};

    always_comb begin
        cond_sel = 1'b1;
        case (uop_cond[2:0])
            3'd1: cond_sel = flags_q[0];
            3'd2: cond_sel = flags_q[2];
            3'd3: cond_sel = flags_q[3];
            3'd4: cond_sel = flags_q[1];
            3'd5: cond_sel = flags_q[0] | flags_q[2];
            3'd6: cond_sel = flags_q[3] ^ flags_q[1];
            3'd7: cond_sel = (flags_q[3] ^ flags_q[1]) | flags_q[2];
            default: cond_sel = 1'b1;
        endcase
    end
    assign taken = cond_sel ^ uop_cond[3];

`ifdef HD63701_EXEC_GEN_TIMEOUT_EN
    localparam int TW = $clog2(WAIT_MAX + 1);
    logic [TW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;

    // Expiry on the edge ending the WAIT_MAX-th MEM cycle; an ack on that edge takes priority.
    assign expired = (state_q == S_MEM) && (cnt_q == TW'(WAIT_MAX - 1));

    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (state_q == S_MEM) begin
            cnt_d = cnt_q + 1'b1;
            if (!mem_ack && expired) err_d = 1'b1;
        end else begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
    assign err = err_q;
`else
    assign expired = 1'b0;
    // WAIT_MAX has no effect without the timeout; referenced here only to keep it live.
    assign err     = 1'b0 & (WAIT_MAX == 0);
`endif

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        pc_d    = pc_q;
        flags_d = flags_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        reg_we  = 1'b0;
        reg_wa  = uop_rd;
        reg_wd  = op_b;
        if (state_q == S_MEM) begin
            if (mem_ack) begin
                state_d = S_IDLE;
                if (!we_q) begin
                    reg_we  = 1'b1;
                    reg_wa  = rd_q;
                    reg_wd  = mem_rdata;
                    flags_d = nz_flags(mem_rdata, flags_q[0]);
                end
            end else if (expired) begin
                state_d = S_IDLE;
            end
        end else if (accept) begin
            pc_d = pc_q + 1'b1;
            case (uop_op)
                OP_LDI: begin reg_we = 1'b1; reg_wd = uop_imm; flags_d = nz_flags(uop_imm, flags_q[0]); end
                OP_MOV: begin reg_we = 1'b1; reg_wd = op_b; flags_d = nz_flags(op_b, flags_q[0]); end
                OP_ADD, OP_ADC: begin
                    reg_we  = 1'b1;
                    reg_wd  = add_sum[DW-1:0];
                    flags_d = {add_sum[DW-1], (add_sum[DW-1:0] == '0),
                               (op_a[DW-1] == op_b[DW-1]) && (add_sum[DW-1] != op_a[DW-1]), add_sum[DW]};
                end
                OP_SUB: begin
                    reg_we  = 1'b1;
                    reg_wd  = sub_dif[DW-1:0];
                    flags_d = {sub_dif[DW-1], (sub_dif[DW-1:0] == '0),
                               (op_a[DW-1] != op_b[DW-1]) && (sub_dif[DW-1] != op_a[DW-1]), sub_dif[DW]};
                end
                OP_AND: begin reg_we = 1'b1; reg_wd = op_a & op_b; flags_d = nz_flags(op_a & op_b, flags_q[0]); end
                OP_OR:  begin reg_we = 1'b1; reg_wd = op_a | op_b; flags_d = nz_flags(op_a | op_b, flags_q[0]); end
                OP_XOR: begin reg_we = 1'b1; reg_wd = op_a ^ op_b; flags_d = nz_flags(op_a ^ op_b, flags_q[0]); end
                OP_LD, OP_ST: begin
                    state_d = S_MEM;
                    addr_d  = x_q + AW'(uop_imm);
                    we_d    = (uop_op == OP_ST);
                    wdata_d = op_a;
                    rd_d    = uop_rd;
                end
                OP_LDX: x_d = AW'({x_q, uop_imm});
                OP_BRA: if (taken) pc_d = pc_q + AW'($signed(uop_imm));
                OP_INX: x_d = x_q + 1'b1;
                OP_TST: flags_d = nz_flags(op_a, 1'b0);
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            pc_q    <= AW'(RESET_PC);
            flags_q <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            pc_q    <= pc_d;
            flags_q <= flags_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else if (reg_we) begin
            regs_q[reg_wa] <= reg_wd;
        end
    end

    assign uop_ready = (state_q == S_IDLE);
    assign mem_req   = (state_q == S_MEM);
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign pc        = pc_q;
    assign flags     = flags_q;
    assign xreg      = x_q;
    assign dbg_data  = regs_q[dbg_sel];
    assign dbg_state = state_q;
endmodule

// File: tb/tb_hd63701_exec_gen.sv
// Randomised bench for hd63701_exec_gen against an arithmetic reference model of the datapath.
module tb_hd63701_exec_gen;
  localparam int DW = 8;
  localparam int AW = 16;
  localparam int NREG = 4;
`ifdef HD63701_EXEC_GEN_TIMEOUT_EN
  localparam int WMAX = 4;
  localparam int NMAX = 4;
`else
  localparam int WMAX = 15;
  localparam int NMAX = 6;
`endif

  // clock / reset
  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  logic          uop_valid = 1'b0;
  logic          uop_ready;
  logic [3:0]    uop_op = '0;
  logic [1:0]    uop_rd = '0;
  logic [1:0]    uop_rs = '0;
  logic [DW-1:0] uop_imm = '0;
  logic [3:0]    uop_cond = '0;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ack = 1'b0;
  logic [AW-1:0] pc, xreg;
  logic [3:0]    flags;
  logic          err;
  logic [1:0]    dbg_sel = '0;
  logic [DW-1:0] dbg_data;
  logic          dbg_state;

  hd63701_exec_gen #(.DW(DW), .AW(AW), .NREG(NREG), .RESET_PC(0), .WAIT_MAX(WMAX)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .uop_valid(uop_valid), .uop_ready(uop_ready), .uop_op(uop_op), .uop_rd(uop_rd),
    .uop_rs(uop_rs), .uop_imm(uop_imm), .uop_cond(uop_cond),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .pc(pc), .flags(flags), .xreg(xreg), .err(err),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data), .dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // reference model state
  int m_r[NREG];
  int m_x, m_pc, m_addr, m_wdata, m_ld_rd;
  bit m_n, m_z, m_v, m_c, m_busy, m_we, m_err;
  bit cmp_en = 1'b0;
  bit dbg_auto = 1'b0;

  function automatic int sx(input int v);
    return (v >= 128) ? v - 256 : v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) m_r[i] = 0;
    m_x = 0; m_pc = 0; m_addr = 0; m_wdata = 0; m_ld_rd = 0;
    m_n = 0; m_z = 0; m_v = 0; m_c = 0; m_busy = 0; m_we = 0; m_err = 0;
  endtask

  task automatic set_nz(input int r);
    m_n = (r >= 128); m_z = (r == 0); m_v = 0;
  endtask

  function automatic bit cond_ok(input logic [3:0] c);
    bit t;
    case (int'(c[2:0]))
      0: t = 1;
      1: t = m_c;
      2: t = m_z;
      3: t = m_n;
      4: t = m_v;
      5: t = m_c | m_z;
      6: t = m_n ^ m_v;
      default: t = (m_n ^ m_v) | m_z;
    endcase
    return t ^ c[3];
  endfunction

  task automatic model_accept(input int op, input int rd, input int rs, input int imm, input logic [3:0] cond);
    int a, b, s, ss, res, old_pc;
    a = m_r[rd]; b = m_r[rs]; old_pc = m_pc;
    m_pc = (m_pc + 1) % 65536;
    case (op)
      1: begin m_r[rd] = imm; set_nz(imm); end
      2: begin m_r[rd] = b; set_nz(b); end
      3, 4: begin
        s = a + b + ((op == 4) ? int'(m_c) : 0);
        ss = sx(a) + sx(b) + ((op == 4) ? int'(m_c) : 0);
        res = s % 256;
        m_r[rd] = res; m_n = (res >= 128); m_z = (res == 0);
        m_c = (s > 255); m_v = (ss > 127) || (ss < -128);
      end
      5: begin
        res = (a - b + 256) % 256;
        ss = sx(a) - sx(b);
        m_r[rd] = res; m_n = (res >= 128); m_z = (res == 0);
        m_c = (a < b); m_v = (ss > 127) || (ss < -128);
      end
      6: begin m_r[rd] = a & b; set_nz(a & b); end
      7: begin m_r[rd] = a | b; set_nz(a | b); end
      8: begin m_r[rd] = a ^ b; set_nz(a ^ b); end
      9, 10: begin
        m_busy = 1; m_addr = (m_x + imm) % 65536; m_we = (op == 10);
        m_wdata = a; m_ld_rd = rd;
      end
      11: m_x = (m_x * 256 + imm) % 65536;
      12: if (cond_ok(cond)) m_pc = (old_pc + sx(imm) + 65536) % 65536;
      13: m_x = (m_x + 1) % 65536;
      14: begin set_nz(a); m_c = 0; end
      default: ;
    endcase
  endtask

  // compare process: checks every visible output against the model each cycle
  always @(negedge CLK) begin
    if (RST_N && cmp_en) begin
      chk("pc", pc, m_pc);
      chk("flags", flags, {m_n, m_z, m_v, m_c});
      chk("xreg", xreg, m_x);
      chk("dbg_data", dbg_data, m_r[dbg_sel]);
      chk("uop_ready", uop_ready, !m_busy);
      chk("mem_req", mem_req, m_busy);
      chk("err", err, m_err);
      if (m_busy) begin
        chk("mem_addr", mem_addr, m_addr);
        chk("mem_we", mem_we, m_we);
        if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
      end
    end
  end

  initial begin
    forever begin
      @(posedge CLK);
      #2;
      if (dbg_auto) dbg_sel = 2'($urandom_range(0, NREG - 1));
    end
  end

  // driver tasks: all start and end just after a falling edge
  task automatic garbage();
    uop_valid = 1'($urandom_range(0, 1));
    uop_op = 4'($urandom); uop_rd = 2'($urandom); uop_rs = 2'($urandom);
    uop_imm = 8'($urandom); uop_cond = 4'($urandom); mem_rdata = 8'($urandom);
  endtask

  task automatic send(input int op, input int rd, input int rs, input int imm, input int cond);
    uop_valid = 1'b1; uop_op = 4'(op); uop_rd = 2'(rd); uop_rs = 2'(rs);
    uop_imm = 8'(imm); uop_cond = 4'(cond);
    mem_ack = 1'($urandom_range(0, 1));
    mem_rdata = 8'($urandom);
    @(posedge CLK);
    model_accept(op, rd, rs, imm, 4'(cond));
    @(negedge CLK);
    uop_valid = 1'b0; mem_ack = 1'b0;
  endtask

  task automatic mem_phase(input int n, input int rdata);
    for (int i = 1; i < n; i++) begin
      garbage();
      @(posedge CLK);
      @(negedge CLK);
    end
    garbage();
    mem_ack = 1'b1; mem_rdata = 8'(rdata);
    @(posedge CLK);
    if (!m_we) begin m_r[m_ld_rd] = rdata; set_nz(rdata); end
    m_busy = 0;
    @(negedge CLK);
    mem_ack = 1'b0; uop_valid = 1'b0;
  endtask

  task automatic lit_reg(input string name, input int idx, input int exp);
    dbg_auto = 1'b0;
    dbg_sel = 2'(idx);
    #1;
    chk(name, dbg_data, exp);
    dbg_auto = 1'b1;
  endtask

  task automatic reset_mid();
    uop_valid = 1'b0; mem_ack = 1'b0;
    @(posedge CLK);
    #3;
    RST_N = 1'b0;
    model_reset();
    #1;
    chk("rst_mid_mem_req", mem_req, 0);
    chk("rst_mid_ready", uop_ready, 1);
    chk("rst_mid_err", err, 0);
    @(negedge CLK);
    #1;
    RST_N = 1'b1;
    @(negedge CLK);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int op, n;
    model_reset();
    // reset state
    #12;
    chk("rst_pc", pc, 0);
    chk("rst_flags", flags, 0);
    chk("rst_xreg", xreg, 0);
    chk("rst_ready", uop_ready, 1);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_err", err, 0);
    for (int i = 0; i < NREG; i++) begin
      dbg_sel = 2'(i);
      #1;
      chk("rst_reg", dbg_data, 0);
    end
    @(negedge CLK);
    #1;
    RST_N = 1'b1;
    cmp_en = 1'b1;
    dbg_auto = 1'b1;
    @(negedge CLK);

    // directed sequence with hand-computed results
    send(1, 0, 0, 8'h7F, 0);
    send(1, 1, 0, 8'h01, 0);
    send(3, 0, 1, 0, 0);
    lit_reg("add_r0", 0, 8'h80);
    chk("add_flags", flags, 4'hA);
    chk("add_pc", pc, 16'h0003);
    send(1, 0, 0, 8'h00, 0);
    send(5, 0, 1, 0, 0);
    lit_reg("sub_r0", 0, 8'hFF);
    chk("sub_flags", flags, 4'h9);
    send(4, 0, 1, 0, 0);
    lit_reg("adc_r0", 0, 8'h01);
    chk("adc_flags", flags, 4'h1);
    send(11, 0, 0, 8'h12, 0);
    send(11, 0, 0, 8'h34, 0);
    chk("ldx_x", xreg, 16'h1234);
    send(10, 1, 0, 8'h05, 0);
    chk("st_addr", mem_addr, 16'h1239);
    chk("st_we", mem_we, 1);
    chk("st_wdata", mem_wdata, 8'h01);
    mem_phase(3, 0);
    chk("st_ready_after", uop_ready, 1);
    send(11, 0, 0, 8'hFF, 0);
    send(11, 0, 0, 8'hFF, 0);
    send(9, 2, 0, 8'h00, 0);
    chk("ld_addr_wrap", mem_addr, 16'hFFFF);
    mem_phase(1, 8'h00);
    lit_reg("ld_r2", 2, 8'h00);
    chk("ld_flags", flags, 4'h5);
    for (int i = 0; i < 4; i++) send(0, 0, 0, 0, 0);
    chk("pre_bra_pc", pc, 16'h0010);
    send(12, 0, 0, 8'hFC, 4'h2);
    chk("bra_taken_pc", pc, 16'h000C);
    send(12, 0, 0, 8'h40, 4'hA);
    chk("bra_not_taken_pc", pc, 16'h000D);

    // randomised stream
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        uop_valid = 1'b0;
        mem_ack = 1'($urandom_range(0, 1));
        @(posedge CLK);
        @(negedge CLK);
        mem_ack = 1'b0;
      end
      op = $urandom_range(0, 15);
      send(op, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 255), $urandom_range(0, 15));
      if (op == 9 || op == 10) begin
        n = $urandom_range(1, NMAX);
        mem_phase(n, $urandom_range(0, 255));
      end
    end

`ifdef HD63701_EXEC_GEN_TIMEOUT_EN
    // ack arriving on the expiry edge wins
    send(9, 3, 0, 8'h10, 0);
    mem_phase(WMAX, 8'h5A);
    chk("tmo_ack_wins_err", err, 0);
    // hung cycle aborts after WMAX cycles
    send(9, 1, 0, 8'h20, 0);
    for (int i = 1; i <= WMAX; i++) begin
      garbage();
      @(posedge CLK);
      if (i == WMAX) begin m_busy = 0; m_err = 1; end
      @(negedge CLK);
    end
    uop_valid = 1'b0;
    chk("tmo_err", err, 1);
    chk("tmo_mem_req", mem_req, 0);
    send(0, 0, 0, 0, 0);
    send(9, 2, 0, 8'h01, 0);
    @(posedge CLK);
    @(negedge CLK);
    reset_mid();
`else
    // without the timeout a hung cycle stays pending
    send(9, 1, 0, 8'h20, 0);
    for (int i = 0; i < 100; i++) begin
      garbage();
      @(posedge CLK);
      @(negedge CLK);
    end
    uop_valid = 1'b0;
    chk("hang_mem_req", mem_req, 1);
    reset_mid();
`endif

    // short post-reset stream
    send(1, 2, 0, 8'h80, 0);
    send(14, 2, 0, 0, 0);
    chk("post_rst_tst_flags", flags, 4'h8);
    chk("post_rst_pc", pc, 16'h0002);
    for (int k = 0; k < 40; k++) begin
      op = $urandom_range(0, 15);
      send(op, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 255), $urandom_range(0, 15));
      if (op == 9 || op == 10) mem_phase($urandom_range(1, NMAX), $urandom_range(0, 255));
    end

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/hd63701_exec_gen.md
# hd63701_exec_gen

Parametrised successor to the HD63701 execution datapath. It executes a stream of micro-ops from the sequencer over a valid/ready handshake, against a register file of configurable depth and width. It also provides a 4-flag condition register, an index register X and a program counter. Memory micro-ops run a request/acknowledge bus cycle with any number of wait states, and an optional bus timeout can abort a hung cycle.

## Interface
- DW, 8, data/register width (8 or 16)
- AW, 16, address width (AW ≥ DW)
- NREG, 4, register count; power of 2, ≥ 2; index width RI = $clog2(NREG)
- RESET_PC, 0, PC value after reset
- WAIT_MAX, 15, timeout length in cycles (used only with the timeout macro)
- CLK  in  1  clock; all state changes on the rising edge
- RST_N  in  1  asynchronous, active-low reset
- uop_valid  in  1  micro-op present
- uop_ready  out  1  micro-op accepted when valid & ready at the rising edge
- uop_op  in  4  opcode
- uop_rd  in  RI  destination/source A
- uop_rs  in  RI  source B
- uop_imm  in  DW  immediate
- uop_cond  in  4  branch condition
- mem_req  out  1  bus cycle active
- mem_we  out  1  1 = write
- mem_addr  out  AW  bus address
- mem_wdata  out  DW  write data
- mem_rdata  in  DW  read data, valid with mem_ack
- mem_ack  in  1  cycle complete
- pc  out  AW  program counter
- flags  out  4  {N,Z,V,C}
- xreg  out  AW  index register X
- err  out  1  sticky bus-timeout flag
- dbg_sel  in  RI  register-file read select
- dbg_data  out  DW  R[dbg_sel], combinational

## Operation
- Opcodes:
  - 0 NOP
  - 1 LDI: R[rd] ← imm
  - 2 MOV: R[rd] ← R[rs]
  - 3 ADD: R[rd] ← R[rd] + R[rs]
  - 4 ADC: R[rd] ← R[rd] + R[rs] + C
  - 5 SUB: R[rd] ← R[rd] − R[rs]
  - 6 AND, 7 OR, 8 XOR: R[rd] ← R[rd] op R[rs]
  - 9 LD: R[rd] ← mem[X+imm]
  - A ST: mem[X+imm] ← R[rd]
  - B LDX: X ← (X << DW) | imm, truncated to AW
  - C BRA: conditional branch
  - D INX: X ← X+1
  - E TST: flags from R[rd]
  - F: NOP
- Address X+imm: imm is zero-extended; the sum wraps modulo 2^AW.
- Flags:
  - ADD/ADC/SUB: set N, Z, V, C. For SUB, C = borrow and V = signed overflow.
  - AND/OR/XOR/LDI/MOV/LD/TST: set N and Z from the result, clear V. C is unchanged, except TST also clears C.
  - All other opcodes leave the flags unchanged.
- PC:
  - Every accepted micro-op updates PC to pc+1.
  - A taken BRA updates PC to pc + sign-extended imm instead.
  - PC wraps modulo 2^AW.
- BRA condition:
  - uop_cond[2:0] selects the test: 0 always, 1 C, 2 Z, 3 N, 4 V, 5 C|Z, 6 N^V, 7 (N^V)|Z.
  - uop_cond[3] inverts the selected test.
- State machine:
  - IDLE: uop_ready=1. Non-memory ops complete on the accept edge, and the machine stays in IDLE. LD/ST latch address, wdata, we and rd, then go to MEM.
  - MEM: uop_ready=0, mem_req=1. On mem_ack, LD writes R[rd] and flags from mem_rdata, then the machine returns to IDLE.
- Register aliasing: rd==rs is legal, and sources are read before the write.
- mem_ack outside MEM is ignored.
- uop_valid while in MEM is not accepted; the micro-op must be held by the sender.

## Timing
- Reset values (asynchronous):
  - all R = 0, X = 0, pc = RESET_PC, flags = 0
  - state IDLE, uop_ready = 1
  - mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, err = 0
- Latency:
  - Register/flag/PC results are visible the cycle after the accept edge.
  - mem_req rises the cycle after LD/ST acceptance.
  - mem_req falls, and uop_ready rises, the cycle after the mem_ack edge.
  - Minimum LD/ST occupancy is 2 cycles; each extra cycle without mem_ack adds one.
- mem_addr, mem_we and mem_wdata stay stable for the whole time mem_req=1.
- Reset mid-access: mem_req drops immediately, and no register or flag is written.

## Configuration
- HD63701_EXEC_GEN_TIMEOUT_EN defined:
  - A counter starts at MEM entry.
  - If mem_ack has not arrived after WAIT_MAX cycles in MEM, the cycle is aborted: mem_req drops, the machine returns to IDLE, err is set, and R[rd] and flags are unchanged.
  - An ack arriving on the same edge as timeout expiry wins.
  - err clears only on reset.
- Undefined: no counter, MEM waits indefinitely, and err is tied to 0.

## Test plan
- DW=8: LDI r0,0x7F; LDI r1,0x01; ADD r0,r1 -> dbg r0=0x80, flags N=1 Z=0 V=1 C=0; pc advanced by 3.
- SUB with r0=0x00, r1=0x01 -> r0=0xFF, N=1 C=1 V=0 Z=0; then ADC r0,r1 -> r0=0x01, C=1.
- LDX 0x12; LDX 0x34; ST r1 with imm 0x05; ack after 3 cycles -> mem_addr=0x1239, mem_we=1, mem_wdata=0x01, uop_ready=0 for 3 cycles, then 1.
- LD r2 with imm 0x00 at X=0xFFFF -> mem_addr=0xFFFF; rdata 0x00 with ack -> r2=0x00, Z=1, C unchanged.
- pc=0x0010, Z=1: BRA cond=2, imm=0xFC -> pc=0x000C; BRA cond=0xA -> pc=0x000D.
- With the macro and WAIT_MAX=4: LD with no ack -> mem_req drops after 4 cycles, err=1, rd unchanged. Without the macro: mem_req stays high for 100 cycles. Asserting RST_N low mid-cycle -> mem_req=0 immediately.
